// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive frame checker.
package hdlc_pkg;

  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_R = 16'h8408;
  localparam logic [15:0] CRC_GOOD   = 16'hF0B8;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_OVLEN = 2'd2,
    ERR_ABORT = 2'd3
  } hdlc_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_OVFL = 2'd2
  } hdlc_rx_state_e;

endpackage

// File: rtl/hdlc_crc16_x25.sv
// Combinational byte-wide CRC-16/X.25 step (reflected, bit 0 first).
// Shared with the transmit path.
module hdlc_crc16_x25
  import hdlc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/hdlc_rx_fcs_chk.sv
// Frame checker after the HDLC bit receiver: CRC residue, length class, status, irq.
// Optional good/bad frame counters are built when HDLC_RX_ERR_CNT_EN is defined.
//
// state   | meaning
// IDLE    | no bytes of a frame received yet
// RECV    | accumulating a frame
// OVFL    | length exceeded, discarding bytes until a delimiter
module hdlc_rx_fcs_chk
  import hdlc_pkg::*;
#(
  parameter int MAX_LEN = 512,
  parameter int MIN_LEN = 4,
  parameter int IRQ_CYC = 100
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  input  logic        frame_end,
  input  logic        frame_abort,
  output logic        stat_vld,
  output logic [9:0]  stat_len,
  output logic        stat_fcs_ok,
  output logic [1:0]  stat_err,
  output logic        irq,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int              IRQ_W    = $clog2(IRQ_CYC + 1);
  localparam logic [9:0]      MAX_L    = 10'(MAX_LEN);
  localparam logic [9:0]      MIN_L    = 10'(MIN_LEN);
  localparam logic [IRQ_W-1:0] IRQ_LOAD = IRQ_W'(IRQ_CYC);

  hdlc_rx_state_e   state_q, state_d;
  logic [15:0]      crc_q, crc_d, crc_seed, crc_upd;
  logic [9:0]       cnt_q, cnt_d, close_len;
  logic             take, close, close_ok;
  hdlc_err_e        close_err;
  logic [IRQ_W-1:0] irq_cnt_q;

  assign crc_seed = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

  hdlc_crc16_x25 u_crc (
    .crc_in  (crc_seed),
    .data_in (byte_data),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    close     = 1'b0;
    close_ok  = 1'b0;
    close_err = ERR_NONE;
    // an abort in the same cycle drops the byte
    take      = byte_vld && !frame_abort;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_RECV;
          crc_d   = crc_upd;
          cnt_d   = 10'd1;
        end
      end
      ST_RECV: begin
        if (take) begin
          crc_d = crc_upd;
          if (cnt_q == MAX_L) state_d = ST_OVFL;
          else                cnt_d   = cnt_q + 10'd1;
        end
      end
      default: ;
    endcase

    // a byte arriving with frame_end belongs to the closing frame
    close_len = cnt_d;
    if (frame_abort && state_q != ST_IDLE) begin
      close     = 1'b1;
      close_err = ERR_ABORT;
    end else if (frame_end && state_d != ST_IDLE) begin
      close = 1'b1;
      if (state_d == ST_OVFL)  close_err = ERR_OVLEN;
      else if (cnt_d < MIN_L)  close_err = ERR_SHORT;
      close_ok = (close_err == ERR_NONE) && (crc_d == CRC_GOOD);
    end

    if (close) begin
      state_d = ST_IDLE;
      crc_d   = CRC_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      stat_vld    <= 1'b0;
      stat_len    <= '0;
      stat_fcs_ok <= 1'b0;
      stat_err    <= ERR_NONE;
      irq_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      stat_vld <= close;
      if (close) begin
        stat_len    <= close_len;
        stat_fcs_ok <= close_ok;
        stat_err    <= close_err;
      end
      // a good frame during the hold reloads, stretching the pulse
      if (close && close_ok)    irq_cnt_q <= IRQ_LOAD;
      else if (irq_cnt_q != '0) irq_cnt_q <= irq_cnt_q - IRQ_W'(1);
    end
  end

  assign irq = (irq_cnt_q != '0);

`ifdef HDLC_RX_ERR_CNT_EN
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (close) begin
      if (close_ok) frame_cnt <= frame_cnt + 16'd1;
      else          err_cnt   <= err_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_hdlc_rx_fcs_chk.sv
// Self-checking bench for hdlc_rx_fcs_chk: directed frames plus random frames
// checked against a frame-level reference model.
module tb_hdlc_rx_fcs_chk;

  localparam int MAX_LEN = 512;
  localparam int MIN_LEN = 4;
  localparam int IRQ_CYC = 100;
`ifdef HDLC_RX_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int due;
    int len;
    bit ok;
    int err;
  } exp_t;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_vld = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        frame_end = 1'b0;
  logic        frame_abort = 1'b0;
  logic        stat_vld;
  logic [9:0]  stat_len;
  logic        stat_fcs_ok;
  logic [1:0]  stat_err;
  logic        irq;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  byte_q_t frm;
  exp_t   exp_q[$];
  int     good_due[$];
  int     m_frames = 0;
  int     m_errs = 0;

  hdlc_rx_fcs_chk #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .IRQ_CYC(IRQ_CYC)) dut (
    .clk_100m    (clk_100m),
    .rst_n       (rst_n),
    .byte_vld    (byte_vld),
    .byte_data   (byte_data),
    .frame_end   (frame_end),
    .frame_abort (frame_abort),
    .stat_vld    (stat_vld),
    .stat_len    (stat_len),
    .stat_fcs_ok (stat_fcs_ok),
    .stat_err    (stat_err),
    .irq         (irq),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk_100m = ~clk_100m;
  always @(posedge clk_100m) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // bit-serial reference CRC over a whole frame
  function automatic logic [15:0] crc_ref(input byte_q_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[i][b]) c = (c >> 1) ^ 16'h8408;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic void push_stat(input bit aborted);
    exp_t e;
    int   n;
    n     = frm.size();
    e.due = cyc + 1;
    e.len = (n > MAX_LEN) ? MAX_LEN : n;
    e.ok  = 1'b0;
    if (aborted)           e.err = 3;
    else if (n > MAX_LEN)  e.err = 2;
    else if (n < MIN_LEN)  e.err = 1;
    else begin
      e.err = 0;
      e.ok  = (crc_ref(frm) == 16'hF0B8);
    end
    exp_q.push_back(e);
    if (e.ok) good_due.push_back(e.due);
  endfunction

  // drive one cycle of inputs and update the reference model
  task automatic drive_cyc(input bit v, input logic [7:0] d, input bit e, input bit a);
    @(posedge clk_100m);
    #1;
    byte_vld    = v;
    byte_data   = d;
    frame_end   = e;
    frame_abort = a;
    if (a) begin
      if (frm.size() > 0) push_stat(1'b1);
      frm.delete();
    end else begin
      if (v) frm.push_back(d);
      if (e && frm.size() > 0) begin
        push_stat(1'b0);
        frm.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // close_mode: 0 = separate frame_end, 1 = end with last byte, 2 = abort, 3 = end+abort
  task automatic send_frame(input byte_q_t q, input int close_mode);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && close_mode == 1) drive_cyc(1'b1, q[i], 1'b1, 1'b0);
      else                               drive_cyc(1'b1, q[i], 1'b0, 1'b0);
    end
    if (close_mode == 0 || n == 0) drive_cyc(1'b0, 8'h00, 1'b1, 1'b0);
    else if (close_mode == 2)      drive_cyc(1'b0, 8'h00, 1'b0, 1'b1);
    else if (close_mode == 3)      drive_cyc(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk_100m);
    #1;
    byte_vld = 1'b0; frame_end = 1'b0; frame_abort = 1'b0;
    rst_n = 1'b0;
    frm.delete(); exp_q.delete(); good_due.delete();
    m_frames = 0; m_errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100m);
      chk("rst_stat_vld", stat_vld, 0);
      chk("rst_stat_len", stat_len, 0);
      chk("rst_fcs_ok", stat_fcs_ok, 0);
      chk("rst_err", stat_err, 0);
      chk("rst_irq", irq, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
    end
    @(posedge clk_100m);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk_100m) begin : mon
    exp_t e;
    bit   ev;
    bit   irq_e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("stat_vld", stat_vld, ev);
    if (ev) begin
      e = exp_q.pop_front();
      chk("stat_len", stat_len, e.len);
      chk("stat_fcs_ok", stat_fcs_ok, e.ok);
      chk("stat_err", stat_err, e.err);
      if (e.ok) m_frames++;
      else      m_errs++;
      chk("frame_cnt", frame_cnt, CNT_ON ? m_frames : 0);
      chk("err_cnt", err_cnt, CNT_ON ? m_errs : 0);
    end
    irq_e = 1'b0;
    foreach (good_due[i]) if (good_due[i] <= cyc && cyc < good_due[i] + IRQ_CYC) irq_e = 1'b1;
    chk("irq", irq, irq_e);
  end

  byte_q_t good_f, bad_f, q;
  logic [15:0] f;
  int n, mode;

  initial begin
    good_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    bad_f  = good_f;
    bad_f[10] = 8'h91;

    do_reset(3);
    idle(2);

    send_frame(good_f, 0);
    idle(3);
    chk("plan_good_len", stat_len, 11);
    chk("plan_good_ok", stat_fcs_ok, 1);
    chk("plan_good_err", stat_err, 0);
    idle(110);

    send_frame(bad_f, 0);
    idle(3);
    chk("plan_badfcs_ok", stat_fcs_ok, 0);
    chk("plan_badfcs_err", stat_err, 0);

    q = '{8'hAA, 8'h55};
    send_frame(q, 0);
    idle(3);
    chk("plan_short_len", stat_len, 2);
    chk("plan_short_err", stat_err, 1);
    drive_cyc(1'b0, 8'h00, 1'b1, 1'b0);
    drive_cyc(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);

    q.delete();
    for (int i = 0; i < 600; i++) q.push_back(8'($urandom));
    send_frame(q, 0);
    idle(3);
    chk("plan_ovlen_len", stat_len, 512);
    chk("plan_ovlen_err", stat_err, 2);

    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(q, 2);
    idle(3);
    chk("plan_abort_err", stat_err, 3);
    chk("plan_abort_ok", stat_fcs_ok, 0);

    drive_cyc(1'b1, 8'h11, 1'b0, 1'b0);
    drive_cyc(1'b1, 8'h22, 1'b0, 1'b1);
    idle(3);

    send_frame(good_f, 1);
    send_frame(good_f, 1);
    idle(40);
    send_frame(good_f, 0);
    idle(20);

    for (int i = 0; i < 6; i++) drive_cyc(1'b1, good_f[i], 1'b0, 1'b0);
    do_reset(2);
    send_frame(good_f, 0);
    idle(3);
    chk("plan_rst_len", stat_len, 11);
    chk("plan_rst_ok", stat_fcs_ok, 1);
    idle(105);

    for (int k = 0; k < 60; k++) begin
      q.delete();
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      mode = $urandom_range(0, 3);
      if (mode <= 1) begin
        f = ~crc_ref(q);
        if (mode == 1) f[$urandom_range(0, 15)] ^= 1'b1;
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
      end
      n = $urandom_range(0, 9);
      send_frame(q, (n < 4) ? 0 : (n < 8) ? 1 : (n == 8) ? 2 : 3);
      idle($urandom_range(0, 3));
    end
    idle(120);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("final_frame_cnt", frame_cnt, CNT_ON ? m_frames : 0);
    chk("final_err_cnt", err_cnt, CNT_ON ? m_errs : 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
